// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter slice.
// Holds the arbiter FSM state encoding and the default parameter values
// used by spi_arbiter and its round-robin picker.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 40;

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Round-robin picker: combinational search for the first set request bit,
// starting one position after the previous grant and wrapping around.
// Ports:
//   req        - per-requester request vector
//   last_grant - index granted most recently
//   idx        - winning index (valid when any is high)
//   any        - at least one request bit is set
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int unsigned pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(last_grant) + 32'd1 + k) % N_REQ;
      if (!any && req[IW'(pos)]) begin
        any = 1'b1;
        idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// SPI arbiter: shares one SPI master among N_REQ requesters.
// A round-robin winner is picked in IDLE, its TX byte is handed to the
// master with a one-cycle start pulse, and the RX byte (or a timeout flag)
// is returned to the winner with a one-cycle response strobe.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req         - per-requester level-held request
//   req_data    - per-requester TX byte, slice i = [8*i+7:8*i]
//   rsp_valid   - one-cycle response strobe to the granted requester
//   rsp_data    - RX byte (8'h00 on timeout), valid with rsp_valid
//   rsp_err     - timeout flag, valid with rsp_valid
//   busy        - state is not IDLE
//   m_start     - start pulse to the SPI master
//   m_data_in   - TX byte to the SPI master
//   m_data_out  - RX byte from the SPI master
//   m_done      - completion pulse from the SPI master
//   m_cs        - chip select from the SPI master, active-low
//   cs_n        - per-slave chip select, active-low
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 m_start,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out,
  input  logic                 m_done,
  input  logic                 m_cs,
  output logic [N_REQ-1:0]     cs_n
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [CW-1:0]   cnt;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // cnt counts cycles since m_start: 0 during LAUNCH, so the timeout
  // compare at TIMEOUT-1 puts rsp_valid exactly TIMEOUT cycles after m_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
      m_start    <= 1'b0;
      m_data_in  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      m_start   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt       <= pick_idx;
            m_data_in <= req_data[32'(pick_idx)*8 +: 8];
            m_start   <= 1'b1;
            cnt       <= '0;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= cnt + 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (m_done) begin
            rsp_data       <= m_data_out;
            rsp_err        <= 1'b0;
            rsp_valid[gnt] <= 1'b1;
            state          <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_data       <= '0;
            rsp_err        <= 1'b1;
            rsp_valid[gnt] <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= gnt;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // Gated by rst so an aborted transfer releases its slave in the reset cycle.
  always_comb begin
    cs_n = '1;
    if (!rst && (state == ST_LAUNCH || state == ST_WAIT)) begin
      cs_n[gnt] = m_cs;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int TO = 40;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  req_data;
  logic [3:0]   rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         m_start;
  logic [7:0]   m_data_in;
  logic [7:0]   m_data_out;
  logic         m_done;
  logic         m_cs;
  logic [3:0]   cs_n;

  int checks = 0;
  int errors = 0;
  int last_g = N - 1;

  spi_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_done     (m_done),
    .m_cs       (m_cs),
    .cs_n       (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // At most one slave selected in any cycle.
  always @(negedge clk) check("mutex", 32'($countones(~cs_n) <= 1), 32'd1);

  // Winner: first set bit scanning upward from the slot after the last grant.
  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (last + 1 + k) % N;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_cs_n", 32'(cs_n), 32'hF);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req    = '0;
    m_done = 1'b0;
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'hF);
    rst    = 1'b0;
    last_g = N - 1;
  endtask

  // d in 1..TO-1: m_done in the cycle d after m_start; otherwise no m_done (timeout).
  // lat: negedges from the caller's current negedge until the LAUNCH cycle.
  task automatic run_txn(input logic [3:0] pat, input int d, input logic [7:0] rx,
                         input logic [3:0] next_req, input int lat, input bit noise);
    int w;
    int resp_k;
    bit done_ok;
    logic [7:0] exp_tx;
    logic [3:0] exp_cs;
    w       = rr_pick(pat, last_g);
    done_ok = (d >= 1 && d <= TO - 1);
    resp_k  = done_ok ? d + 1 : TO;
    m_data_out = rx;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("pre_start", 32'(m_start), 32'd0);
      check("pre_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    exp_tx = req_data[8*w +: 8];
    for (int k = 0; k <= resp_k; k++) begin
      if (k > 0) @(negedge clk);
      exp_cs = 4'hF;
      if (k < resp_k) exp_cs[w] = m_cs;
      check("m_start", 32'(m_start), 32'(k == 0));
      check("busy", 32'(busy), 32'd1);
      check("cs_n", 32'(cs_n), 32'(exp_cs));
      check("m_data_in", 32'(m_data_in), 32'(exp_tx));
      check("rsp_valid", 32'(rsp_valid), (k == resp_k) ? (32'd1 << w) : 32'd0);
      if (k == resp_k) begin
        check("rsp_data", 32'(rsp_data), done_ok ? 32'(rx) : 32'd0);
        check("rsp_err", 32'(rsp_err), 32'(!done_ok));
      end
      if (k > 0 && k < resp_k) m_done = done_ok && (k == d);
      else                     m_done = 1'($urandom_range(0, 1));
      m_cs = ($urandom_range(0, 3) == 0);
      if (k == resp_k) req = next_req;
      else if (noise) begin
        req      = 4'($urandom);
        req_data = $urandom;
      end
    end
    last_g = w;
  endtask

  initial begin
    logic [3:0] cur, nxt;
    int lat, d, sel;
    rst = 1'b1; req = '0; req_data = '0; m_data_out = '0; m_done = 1'b0; m_cs = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'hF);
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request from requester 2.
    req_data = 32'h77A5_3311; req = 4'b0100;
    run_txn(4'b0100, 5, 8'h3C, 4'b0000, 1, 1'b0);
    idle(2);

    // Contention after reset: grants 0,1,2,3 with their own bytes.
    do_reset();
    idle(1);
    req_data = 32'hD4C3_B2A1; req = 4'b1111;
    run_txn(4'b1111, 3, 8'h10, 4'b1111, 1, 1'b0);
    run_txn(4'b1111, 4, 8'h11, 4'b1111, 2, 1'b0);
    run_txn(4'b1111, 2, 8'h12, 4'b1111, 2, 1'b0);
    run_txn(4'b1111, 6, 8'h13, 4'b0000, 2, 1'b0);
    idle(2);

    // Timeout, then tie at the last WAIT cycle.
    req = 4'b0001;
    run_txn(4'b0001, 0, 8'h5A, 4'b0000, 1, 1'b0);
    idle(1);
    req = 4'b0001;
    run_txn(4'b0001, TO - 1, 8'h96, 4'b0000, 1, 1'b0);
    idle(1);

    // Reset five cycles into the transfer.
    req = 4'b0001; m_done = 1'b0; m_cs = 1'b0;
    @(negedge clk);
    check("mw_m_start", 32'(m_start), 32'd1);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    check("mw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mw_cs_n", 32'(cs_n), 32'hF);
    @(negedge clk);
    check("mw_busy", 32'(busy), 32'd0);
    check("mw_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0; last_g = N - 1;
    idle(3);
    req = 4'b0010;
    run_txn(4'b0010, 7, 8'hE1, 4'b0000, 1, 1'b0);
    idle(1);

    // Randomized traffic with request/data noise during transfers.
    cur = 4'($urandom_range(1, 15));
    req = cur; lat = 1;
    for (int i = 0; i < 25; i++) begin
      nxt = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      sel = $urandom_range(0, 5);
      d = (sel == 0) ? 0 : (sel == 1) ? TO - 1 : $urandom_range(1, 12);
      run_txn(cur, d, 8'($urandom), nxt, lat, 1'b1);
      if (nxt == 4'b0000) begin
        idle(1);
        nxt = 4'($urandom_range(1, 15));
        req = nxt;
        lat = 1;
      end else begin
        lat = 2;
      end
      cur = nxt;
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
